// File: rtl/tx_pkt_fifo_defs.sv
// Shared definitions for the store-and-forward tx packet FIFO: pointer width,
// eop bit position in a stored word, and drop counter width.
package tx_pkt_fifo_defs;

  localparam int DROP_CNT_W = 16;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  function automatic int ptr_w(input int ptr);
    return ptr + 1;
  endfunction

  // The eop flag sits just above the data bits in each RAM word.
  function automatic int eop_bit(input int width);
    return width;
  endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM: one write port and one registered read port, single clock.
module sync_dp_ram #(
  parameter int W     = 257,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tx_pkt_fifo_sf.sv
// Single-clock store-and-forward tx packet FIFO with commit/rollback of packets.
// Optional drop statistics counter enabled by macro TX_PKT_FIFO_STATS_EN.
module tx_pkt_fifo_sf
  import tx_pkt_fifo_defs::*;
#(
  parameter int WIDTH     = 256,
  parameter int DEPTH     = 1024,
  parameter int PTR       = 10,
  parameter int PKT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  wren,
  input  logic [WIDTH-1:0]      datain,
  input  logic                  wr_eop,
  input  logic                  wr_err,
  output logic                  wrfull,
  output logic [PTR:0]          wrusedw,
  input  logic                  rden,
  output logic [WIDTH-1:0]      dataout,
  output logic                  rd_valid,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic                  rdempty,
  output logic [PTR:0]          rdusedw,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int PW      = ptr_w(PTR);
  localparam int EOP_BIT = eop_bit(WIDTH);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 rd_valid_q;
  logic                 sop_q, sop_d;
  logic [WIDTH:0]       ram_rdata;
  logic                 wr_full, wr_store, wr_commit, wr_rollback;
  logic                 rd_accept, eop_read;

  assign wrusedw = wr_ptr_q - rd_ptr_q;
  assign rdusedw = commit_ptr_q - rd_ptr_q;
  assign wr_full = (wrusedw == PW'(DEPTH));
  assign wrfull  = wr_full;
  assign rdempty = (rd_ptr_q == commit_ptr_q);

  // An eop arriving while full is itself an overflow, so it rolls back.
  always_comb begin
    wr_store    = wren & ~wr_full & ~ovf_q & ~(wr_eop & wr_err);
    wr_commit   = wren & wr_eop & ~wr_err & ~ovf_q & ~wr_full;
    wr_rollback = wren & wr_eop & (wr_err | ovf_q | wr_full);
    rd_accept   = rden & ~rdempty;
    eop_read    = rd_valid_q & ram_rdata[EOP_BIT];
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ovf_d        = ovf_q;
    pkt_cnt_d    = pkt_cnt_q;
    sop_d        = sop_q;
    if (wr_rollback) begin
      wr_ptr_d = commit_ptr_q;
      ovf_d    = 1'b0;
    end else begin
      if (wr_store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (wren && wr_full) ovf_d = 1'b1;
    end
    if (wr_commit) commit_ptr_d = wr_ptr_q + PW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_commit && !eop_read && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
    if (!wr_commit && eop_read && pkt_cnt_q != '0) pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
    // The word after an eop word starts a new packet.
    if (rd_valid_q) sop_d = ram_rdata[EOP_BIT];
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      sop_q        <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      ovf_q        <= ovf_d;
      rd_valid_q   <= rd_accept;
      sop_q        <= sop_d;
    end
  end

  sync_dp_ram #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (PTR)
  ) u_ram (
    .clk   (clk),
    .we    (wr_store),
    .waddr (wr_ptr_q[PTR-1:0]),
    .wdata ({wr_eop, datain}),
    .re    (rd_accept),
    .raddr (rd_ptr_q[PTR-1:0]),
    .rdata (ram_rdata)
  );

  assign dataout  = ram_rdata[WIDTH-1:0];
  assign rd_valid = rd_valid_q;
  assign rd_sop   = rd_valid_q & sop_q;
  assign rd_eop   = eop_read;
  assign pkt_cnt  = pkt_cnt_q;

`ifdef TX_PKT_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      drop_cnt_q <= '0;
    end else if (wr_rollback && drop_cnt_q != '1) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_tx_pkt_fifo_sf.sv
// Scoreboard bench for tx_pkt_fifo_sf with a queue-based packet reference model.
module tb_tx_pkt_fifo_sf;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int P  = 4;
  localparam int PC = 8;

  logic          clk = 1'b0;
  logic          reset_;
  logic          wren, wr_eop, wr_err, rden;
  logic [W-1:0]  datain;
  logic          wrfull, rd_valid, rd_sop, rd_eop, rdempty;
  logic [P:0]    wrusedw, rdusedw;
  logic [W-1:0]  dataout;
  logic [PC-1:0] pkt_cnt;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  tx_pkt_fifo_sf #(.WIDTH(W), .DEPTH(D), .PTR(P), .PKT_CNT_W(PC)) dut (
    .clk(clk), .reset_(reset_), .wren(wren), .datain(datain), .wr_eop(wr_eop),
    .wr_err(wr_err), .wrfull(wrfull), .wrusedw(wrusedw), .rden(rden),
    .dataout(dataout), .rd_valid(rd_valid), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .rdempty(rdempty), .rdusedw(rdusedw), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         sop;
    logic         eop;
  } exp_t;

  int         nchk = 0;
  int         nerr = 0;
  logic [W:0] cq[$];
  logic [W:0] pq[$];
  exp_t       expq[$];
  int         m_pkt, m_drop;
  bit         m_ovf, m_sop, m_dec;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_drop();
`ifdef TX_PKT_FIFO_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic check_status();
    chk("wrusedw", 64'(wrusedw), 64'(cq.size() + pq.size()));
    chk("rdusedw", 64'(rdusedw), 64'(cq.size()));
    chk("rdempty", 64'(rdempty), 64'(cq.size() == 0));
    chk("wrfull", 64'(wrfull), 64'((cq.size() + pq.size()) == D));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop()));
  endtask

  task automatic step(bit wr, logic [W-1:0] d, bit eop, bit err, bit rd);
    bit         full_pre, commit, dec_next;
    logic [W:0] w;
    full_pre = (cq.size() + pq.size()) == D;
    commit   = 1'b0;
    dec_next = 1'b0;
    if (rd && cq.size() > 0) begin
      w = cq.pop_front();
      expq.push_back('{d: w[W-1:0], sop: m_sop, eop: w[W]});
      m_sop    = w[W];
      dec_next = w[W];
    end
    if (wr) begin
      if (m_ovf || full_pre) begin
        if (eop) begin
          pq.delete(); m_ovf = 1'b0; m_drop++;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (eop) begin
        if (err) begin
          pq.delete(); m_drop++;
        end else begin
          pq.push_back({1'b1, d});
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
          commit = 1'b1;
        end
      end else begin
        pq.push_back({1'b0, d});
      end
    end
    if (commit && !m_dec && m_pkt < 255) m_pkt++;
    if (!commit && m_dec && m_pkt > 0) m_pkt--;
    m_dec = dec_next;
    wren = wr; datain = d; wr_eop = eop; wr_err = err; rden = rd;
    @(posedge clk);
    #2;
    check_status();
    wren = 1'b0; wr_eop = 1'b0; wr_err = 1'b0; rden = 1'b0;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    wren = 1'b0; wr_eop = 1'b0; wr_err = 1'b0; rden = 1'b0;
    @(posedge clk);
    #2;
    cq.delete(); pq.delete(); expq.delete();
    m_pkt = 0; m_drop = 0; m_ovf = 1'b0; m_sop = 1'b1; m_dec = 1'b0;
    chk("reset_rd_valid", 64'(rd_valid), 64'(0));
    check_status();
    reset_ = 1'b1;
  endtask

  task automatic write_pkt(int len, bit err);
    for (int i = 0; i < len; i++) step(1'b1, $urandom, i == len - 1, err && (i == len - 1), 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (cq.size() > 0 && guard < 200) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("drain_expq_empty", 64'(expq.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_ === 1'b1 && rd_valid === 1'b1) begin
      if (expq.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_rd_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("dataout", 64'(dataout), 64'(e.d));
        chk("rd_sop", 64'(rd_sop), 64'(e.sop));
        chk("rd_eop", 64'(rd_eop), 64'(e.eop));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    bit perr, wr, eop, err;
    reset_ = 1'b0; wren = 1'b0; wr_eop = 1'b0; wr_err = 1'b0; rden = 1'b0; datain = '0;
    do_reset();

    // Basic 4-word packet, then read back.
    write_pkt(4, 1'b0);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(1));
    chk("t1_rdempty", 64'(rdempty), 64'(0));
    drain();
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'(0));

    // Errored packet.
    write_pkt(4, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t3_wrusedw", 64'(wrusedw), 64'(0));

    // Overflow: 20 words plus eop.
    write_pkt(21, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t4_wrusedw", 64'(wrusedw), 64'(0));

    // Wrap: 10 packets of 7 words.
    for (int p = 0; p < 10; p++) begin
      write_pkt(7, 1'b0);
      drain();
    end
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'(0));

    // Commit of B in the same cycle A's eop word is read out.
    write_pkt(4, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_pkt_before", 64'(pkt_cnt), 64'(1));
    step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    chk("t6_pkt_same", 64'(pkt_cnt), 64'(1));
    drain();

    // Reset mid-packet with a read in flight.
    write_pkt(3, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk("t7_rdempty", 64'(rdempty), 64'(1));
    chk("t7_wrusedw", 64'(wrusedw), 64'(0));

    // Randomized traffic.
    left = 0; perr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      wr = 1'b0; eop = 1'b0; err = 1'b0;
      if (left == 0 && $urandom_range(3) == 0) begin
        left = ($urandom_range(9) == 0) ? 18 : int'($urandom_range(8, 1));
        perr = ($urandom_range(7) == 0);
      end
      if (left > 0 && $urandom_range(9) < 7) begin
        wr = 1'b1; eop = (left == 1); err = eop && perr; left--;
      end
      step(wr, $urandom, eop, err, $urandom_range(1) == 1);
    end
    while (left > 0) begin
      step(1'b1, $urandom, left == 1, 1'b0, 1'b0);
      left--;
    end
    drain();
    chk("final_pkt_cnt", 64'(pkt_cnt), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/tx_pkt_fifo_sf.md
Name: tx_pkt_fifo_sf

Overview:
- Single-clock, store-and-forward transmit packet FIFO. It is the parametrised successor to the dual-clock tx packet FIFO wrapper.
- Words are written with an end-of-packet marker. A packet becomes visible to the reader only when its EOP word is written cleanly.
- Errored packets, and packets that overflow the FIFO, are rolled back and discarded.
- Sits between the OmniXtend TX framer and the NETE MAC TX path, where a MAC underrun mid-frame is not permitted.

Parameters:
- WIDTH, 256, data word width in bits.
- DEPTH, 1024, number of words; must be 2**PTR.
- PTR, 10, address width; pointers are PTR+1 bits.
- PKT_CNT_W, 8, width of the committed-packet counter.

Ports:
- clk  in  1  single clock for all logic.
- reset_  in  1  synchronous, active-low reset.
- wren  in  1  write request.
- datain  in  WIDTH  write data.
- wr_eop  in  1  last word of the packet being written.
- wr_err  in  1  packet is bad; sampled only with wren&wr_eop.
- wrfull  out  1  used word count == DEPTH.
- wrusedw  out  PTR+1  words held (committed + speculative).
- rden  in  1  read request.
- dataout  out  WIDTH  read data; registered.
- rd_valid  out  1  dataout/rd_sop/rd_eop valid this cycle.
- rd_sop  out  1  first word of a packet.
- rd_eop  out  1  last word of a packet.
- rdempty  out  1  no committed word available.
- rdusedw  out  PTR+1  committed words not yet read.
- pkt_cnt  out  PKT_CNT_W  complete packets held.
- drop_cnt  out  16  dropped packets (optional feature).

Behaviour:
- Reset, synchronous on clk while reset_=0: pointers wr_ptr=commit_ptr=rd_ptr=0, pkt_cnt=0, drop_cnt=0, rd_valid=0, rd_sop=1 (internal first-word flag), overflow flag=0, rdempty=1, wrfull=0. Reset mid-packet discards everything, including the partial packet.
- Storage: RAM of WIDTH+1 bits; the extra bit holds eop.
- Write: wren&!wrfull&!ovf stores the word at wr_ptr, and wr_ptr increments.
- Clean commit: on wren&wr_eop&!wr_err&!ovf, commit_ptr<=wr_ptr+1 and pkt_cnt increments.
- Rollback: wren&wr_eop with wr_err, or with ovf set, gives wr_ptr<=commit_ptr, ovf<=0, drop_cnt+1. The EOP word is not stored.
- Overflow: wren while wrfull sets ovf. All further words of that packet are discarded until its EOP, which then triggers rollback. A packet longer than DEPTH is therefore always dropped.
- rdempty = (rd_ptr==commit_ptr). rden while rdempty is ignored; no pointer movement and rd_valid=0.
- Read latency is 1 cycle. rden&!rdempty at cycle N gives dataout/rd_valid/rd_eop at N+1.
- rd_sop is high on the first word after reset, and on the word following any eop word.
- pkt_cnt decrements when a word with eop is read. Commit and eop-read in the same cycle leave pkt_cnt unchanged.
- pkt_cnt saturates at all-ones.
- wrusedw = wr_ptr-rd_ptr. rdusedw = commit_ptr-rd_ptr. Both use PTR+1-bit modular subtraction, so wrap-around is handled by the extra MSB.
- Simultaneous read and write in the same cycle are both honoured. A read frees space in the same cycle it is accepted, but wrfull reflects the registered state, so the freed slot is visible next cycle.
- Rollback with a concurrent read: rd_ptr never passes commit_ptr, so no interaction.

Optional Feature:
- Macro: TX_PKT_FIFO_STATS_EN.
- Defined: drop_cnt counts every rollback (error or overflow) and saturates at 16'hFFFF; cleared only by reset.
- Undefined: the drop_cnt port remains and is tied to 0, and no counter logic is built.

Decomposition:
- Shared include/package tx_pkt_fifo_defs: pointer width derivation (PTR+1), the eop bit index (WIDTH), and the drop counter width (16).
- One sub-module: sync_dp_ram, a simple dual-port RAM with WIDTH+1 bits x DEPTH, one write port, and one registered read port.

Test Plan:
- Reset, then write 4 words with eop on word 4 and wr_err=0. Expect rdempty=1 through word 3; rdempty=0 and pkt_cnt=1 the cycle after word 4.
- Read back: words 1..4 out in order, 1-cycle latency. rd_sop on word 1 only, rd_eop on word 4. pkt_cnt returns to 0 and rdempty=1.
- Write 3 words, then eop with wr_err=1. Expect rdusedw=0, wrusedw=0 after the eop, drop_cnt=1 (STATS_EN), and nothing readable.
- Overflow: with DEPTH=16, write 20 words plus eop. Expect wrfull after 16 words, then rollback: wrusedw=0, pkt_cnt=0, drop_cnt=1.
- Wrap: alternate 7-word packet writes and reads for 10 packets (70 words, DEPTH=16). All data must match, pkt_cnt ends at 0, and pointers have wrapped.
- Simultaneous: commit of packet B in the same cycle packet A's eop word is read. Expect pkt_cnt unchanged that cycle. Also assert reset_=0 mid-packet: rdempty=1, wrusedw=0, and rd_valid=0 next cycle.
